// File: rtl/apb_pkg.sv
// Shared types, widths and the address decoder for the APB register slave.
// Ports: none (package only).
package apb_pkg;

    localparam int          APB_DATA_W   = 32;
    localparam int          APB_ADDR_W   = 32;
    localparam logic [31:0] ID_VALUE_DEF = 32'hA9B0_0001;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] idx;
        logic                  err;
    } dec_t;

    // Offset wraps mod 2^32, so addresses below base decode as huge offsets.
    function automatic dec_t apb_decode(
        input logic [APB_ADDR_W-1:0] addr,
        input logic [APB_ADDR_W-1:0] base,
        input int unsigned           num_regs
    );
        logic [APB_ADDR_W-1:0] off;
        dec_t                  d;
        off   = addr - base;
        d.idx = {2'b00, off[APB_ADDR_W-1:2]};
        d.err = (addr[1:0] != 2'b00) ||
                (off >= 32'(4 * num_regs));
        return d;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Register storage: read-only ID at index 0, RW registers above it.
// Ports: clk, rst_n, commit/idx/wdata write port, reg_q flat contents, wr_pulse.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEF,
    parameter int          IW       = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       commit,
    input  logic [IW-1:0]              idx,
    input  logic [APB_DATA_W-1:0]      wdata,
    output logic [NUM_REGS*32-1:0]     reg_q,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    logic [NUM_REGS*32-1:32] rw_q;
    logic [NUM_REGS-1:0]     hit;
    logic [NUM_REGS-1:0]     pulse_q;

    // Index 0 never hits, so its strobe stays low.
    always_comb begin
        hit = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            hit[i] = commit && (idx == IW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_q    <= '0;
            pulse_q <= '0;
        end else begin
            pulse_q <= hit;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (hit[i]) begin
                    rw_q[32*i +: 32] <= wdata;
                end
            end
        end
    end

    assign reg_q    = {rw_q, ID_VALUE};
    assign wr_pulse = pulse_q;

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer with wait states in front of a small register file.
// Ports: PCLK/PRESET, APB completer signals, reg_q contents, wr_pulse strobes.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEF
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [APB_ADDR_W-1:0]  PADDR,
    input  logic [APB_DATA_W-1:0]  PWDATA,
    output logic                   PREADY,
    output logic [APB_DATA_W-1:0]  PRDATA,
    output logic                   PSLVERR,
    output logic [NUM_REGS*32-1:0] reg_q,
    output logic [NUM_REGS-1:0]    wr_pulse
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, err_q;
    logic [APB_DATA_W-1:0] wdata_q, rdata_q;
    logic [IW-1:0]         idx_q;

    dec_t                  dec;
    logic [APB_DATA_W-1:0] rd_mux;
    logic                  setup, done, commit;

    always_comb begin
        dec    = apb_decode(PADDR, BASE_ADDR, NUM_REGS);
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (dec.idx == 32'(i)) begin
                rd_mux = reg_q[32*i +: 32];
            end
        end
    end

    assign setup  = (state_q == IDLE) && PSEL && !PENABLE;
    assign done   = (state_q == ACCESS) && PSEL && PENABLE &&
                    (cnt_q == 4'd0);
    assign commit = done && wr_q && !err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (PENABLE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup) begin
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                idx_q   <= dec.idx[IW-1:0];
                err_q   <= dec.err ||
                           (PWRITE && (dec.idx == '0));
                rdata_q <= dec.err ? '0 : rd_mux;
            end
        end
    end

    // Responses come only from registered state.
    assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign PRDATA  = (PREADY && !wr_q) ? rdata_q : '0;
    assign PSLVERR = PREADY && err_q;

    apb_slave_regfile #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE),
        .IW       (IW)
    ) u_regfile (
        .clk      (PCLK),
        .rst_n    (PRESET),
        .commit   (commit),
        .idx      (idx_q),
        .wdata    (wdata_q),
        .reg_q    (reg_q),
        .wr_pulse (wr_pulse)
    );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench for apb_slave_regs at WAIT_CYCLES of 1, 3 and 0.
// Ports: none (top-level bench).
module tb_apb_slave_regs;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  psel = '0;
    logic        pen = 1'b0;
    logic        pwr = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;

    logic [2:0]   rdy;
    logic [2:0]   serr;
    logic [31:0]  rd [3];
    logic [255:0] rq [3];
    logic [7:0]   wp [3];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int setup_edge = 0;
    int sel = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    logic [31:0] m [3][8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_slave_regs #(.WAIT_CYCLES(1)) u_w1 (
        .PCLK(clk), .PRESET(rst_n), .PSEL(psel[0]),
        .PENABLE(pen), .PWRITE(pwr), .PADDR(paddr),
        .PWDATA(pwdata), .PREADY(rdy[0]), .PRDATA(rd[0]),
        .PSLVERR(serr[0]), .reg_q(rq[0]), .wr_pulse(wp[0])
    );

    apb_slave_regs #(.WAIT_CYCLES(3)) u_w3 (
        .PCLK(clk), .PRESET(rst_n), .PSEL(psel[1]),
        .PENABLE(pen), .PWRITE(pwr), .PADDR(paddr),
        .PWDATA(pwdata), .PREADY(rdy[1]), .PRDATA(rd[1]),
        .PSLVERR(serr[1]), .reg_q(rq[1]), .wr_pulse(wp[1])
    );

    apb_slave_regs #(.WAIT_CYCLES(0)) u_w0 (
        .PCLK(clk), .PRESET(rst_n), .PSEL(psel[2]),
        .PENABLE(pen), .PWRITE(pwr), .PADDR(paddr),
        .PWDATA(pwdata), .PREADY(rdy[2]), .PRDATA(rd[2]),
        .PSLVERR(serr[2]), .reg_q(rq[2]), .wr_pulse(wp[2])
    );

    // Monitor: pop one expectation per PREADY cycle of the active DUT.
    always @(negedge clk) begin
        if (rdy[sel]) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pready: dut=%0d got ready=1 required no transfer", sel);
            end else begin
                me = sb.pop_front();
                if (rd[sel] !== me.rdata || serr[sel] !== me.err ||
                    (cyc - setup_edge) != me.lat) begin
                    n_fail++;
                    $display("FAIL response: dut=%0d got rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                             sel, rd[sel], serr[sel], cyc - setup_edge,
                             me.rdata, me.err, me.lat);
                end
            end
        end
        if (psel[sel] && !pen) setup_edge = cyc + 1;
    end

    function automatic logic [255:0] flat(input int d);
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[32*i +: 32] = m[d][i];
        return f;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m[d][0] = ID;
            for (int i = 1; i < 8; i++) m[d][i] = '0;
        end
    endtask

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        psel = '0;
        pen  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int d, input logic w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee,
                        input int lat);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        e.rdata = er;
        e.err   = ee;
        e.lat   = lat;
        sb.push_back(e);
        sel     = d;
        psel    = '0;
        psel[d] = 1'b1;
        pen     = 1'b0;
        pwr     = w;
        paddr   = a;
        pwdata  = wd;
        @(posedge clk);
        #1 pen = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy[d]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: dut=%0d addr=%h got no PREADY required within 40 cycles", d, a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_pready", rdy[d], 0);
            chk("rst_prdata", rd[d], 0);
            chk("rst_pslverr", serr[d], 0);
            chk("rst_reg_q", rq[d], flat(d));
            chk("rst_wr_pulse", wp[d], 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(0, 1'b0, 32'h0, 32'h0, ID, 1'b0, 1);
        idle();

        xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
        m[0][2] = 32'hDEAD_BEEF;
        chk("wr8_reg_q", rq[0], flat(0));
        chk("wr8_pulse", wp[0], 8'b0000_0100);
        idle();
        chk("wr8_pulse_off", wp[0], 0);
        xfer(0, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
        idle();

        begin
            logic [31:0] bad [3];
            bad[0] = 32'h0;
            bad[1] = 32'h20;
            bad[2] = 32'h6;
            for (int j = 0; j < 3; j++) begin
                xfer(0, 1'b1, bad[j], 32'h5555_AAAA, 32'h0, 1'b1, 1);
                chk("err_wr_reg_q", rq[0], flat(0));
                chk("err_wr_pulse", wp[0], 0);
                idle();
            end
        end
        xfer(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1);
        idle();
        xfer(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1);
        idle();
        xfer(0, 1'b1, 32'h1C, 32'h0BAD_F00D, 32'h0, 1'b0, 1);
        m[0][7] = 32'h0BAD_F00D;
        chk("wr1c_pulse", wp[0], 8'b1000_0000);
        idle();
        xfer(0, 1'b0, 32'h1C, 32'h0, 32'h0BAD_F00D, 1'b0, 1);
        idle();
        chk("wr1c_reg_q", rq[0], flat(0));

        sel    = 1;
        psel   = 3'b010;
        pen    = 1'b0;
        pwr    = 1'b1;
        paddr  = 32'h4;
        pwdata = 32'h1234_5678;
        @(posedge clk);
        #1 pen = 1'b1;
        @(posedge clk);
        #1;
        psel = '0;
        pen  = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pready", rdy[1], 0);
        chk("abort_pulse", wp[1], 0);
        chk("abort_reg_q", rq[1], flat(1));
        @(posedge clk);
        #1;
        chk("abort_pulse2", wp[1], 0);
        xfer(1, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 3);
        idle();

        xfer(1, 1'b1, 32'hC, 32'h0000_1234, 32'h0, 1'b0, 3);
        m[1][3] = 32'h0000_1234;
        chk("wrc_reg_q", rq[1], flat(1));
        idle();
        sel    = 1;
        psel   = 3'b010;
        pen    = 1'b0;
        pwr    = 1'b1;
        paddr  = 32'hC;
        pwdata = 32'hFFFF_0000;
        @(posedge clk);
        #1 pen = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rstw_pready", rdy[1], 0);
        chk("rstw_prdata", rd[1], 0);
        chk("rstw_pslverr", serr[1], 0);
        chk("rstw_pulse", wp[1], 0);
        chk("rstw_reg_q", rq[1], flat(1));
        rst_n = 1'b1;
        psel  = '0;
        pen   = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_pready2", rdy[1], 0);
        chk("rstw_reg_q2", rq[1], flat(1));

        xfer(2, 1'b1, 32'h4, 32'h1, 32'h0, 1'b0, 0);
        m[2][1] = 32'h1;
        chk("b2b_pulse", wp[2], 8'b0000_0010);
        xfer(2, 1'b0, 32'h4, 32'h0, 32'h1, 1'b0, 0);
        idle();
        chk("b2b_reg_q", rq[2], flat(2));

        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
